// File: rtl/gpio_apb_seq.sv
// APB4 master that replays a small step table (register writes, delays, bit polls)
// into the GPIO slave, loaded over a config port and launched by a start pulse.
module gpio_apb_seq #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DELAY_WIDTH = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx_i,
  input  logic [1:0]               cfg_op_i,
  input  logic [3:0]               cfg_reg_i,
  input  logic [31:0]              cfg_arg_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH)-1:0] pc_o,
  output logic [31:0]              paddr_o,
  output logic                     psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [31:0]              pwdata_o,
  output logic [3:0]               pstrb_o,
  input  logic [31:0]              prdata_i,
  input  logic                     pready_i,
  input  logic                     pslverr_i
);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DLY  = 2'b10;
  localparam logic [1:0] OP_POLL = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  rsel;
    logic [31:0] arg;
  } step_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_DELAY, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  step_t                  step_mem [DEPTH];
  step_t                  cur;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic [PW-1:0]          pc_d;
  logic                   err_d;
  logic [31:0]            paddr_d, pwdata_d;
  logic                   pwrite_d;
  logic [3:0]             pstrb_d;
  logic                   adv, abort_now, hit;
  logic [DELAY_WIDTH-1:0] dly;

  assign cur = step_mem[pc_o];

  // Step table: no reset, only writable while the sequencer is idle.
  always_ff @(posedge pclk) begin
    if (cfg_we_i && state_q == S_IDLE) begin
      step_mem[cfg_idx_i] <= step_t'{op: cfg_op_i, rsel: cfg_reg_i, arg: cfg_arg_i};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_o;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    err_d     = err_o;
    paddr_d   = paddr_o;
    pwrite_d  = pwrite_o;
    pwdata_d  = pwdata_o;
    pstrb_d   = pstrb_o;
    adv       = 1'b0;
    abort_now = abort_q | abort_i;
    hit       = (prdata_i & cur.arg) != 32'h0;
    dly       = cur.arg[DELAY_WIDTH-1:0];

    if (state_q != S_IDLE && abort_i) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (abort_now || cur.op == OP_END) begin
          state_d = S_DONE;
        end else if (cur.op == OP_DLY) begin
          if (dly == '0) adv = 1'b1;
          else begin
            state_d = S_DELAY;
            cnt_d   = dly;
          end
        end else begin
          state_d  = S_SETUP;
          paddr_d  = BASE_ADDR + (32'(cur.rsel) << 2);
          pwrite_d = (cur.op == OP_WR);
          pwdata_d = (cur.op == OP_WR) ? cur.arg : 32'h0;
          pstrb_d  = (cur.op == OP_WR) ? 4'hF : 4'h0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_i) begin
          if (pslverr_i) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cur.op == OP_WR || hit) begin
            adv = 1'b1;
          end else if (abort_now) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_DELAY: begin
        if (abort_now) state_d = S_DONE;
        else if (cnt_q == DELAY_WIDTH'(1)) adv = 1'b1;
        else cnt_d = cnt_q - DELAY_WIDTH'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Step completion: stop on abort or at the last entry, never wrap.
    if (adv) begin
      if (abort_now || pc_o == PW'(DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        pc_d    = pc_o + PW'(1);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      pc_o      <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= 32'h0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= 32'h0;
      pstrb_o   <= 4'h0;
    end else begin
      state_q   <= state_d;
      pc_o      <= pc_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      err_o     <= err_d;
      busy_o    <= (state_d != S_IDLE);
      done_o    <= (state_d == S_DONE);
      psel_o    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_o <= (state_d == S_ACCESS);
      paddr_o   <= paddr_d;
      pwrite_o  <= pwrite_d;
      pwdata_o  <= pwdata_d;
      pstrb_o   <= pstrb_d;
    end
  end
endmodule

// File: tb/tb_gpio_apb_seq.sv
// Directed bench for gpio_apb_seq: a transfer-level program model predicts the APB
// write/read sequence, error flag and final pc; a scripted slave answers every access.
module tb_gpio_apb_seq;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam logic [31:0] BASE  = 32'h4000_1000;
  localparam logic [1:0] OP_END = 2'b00, OP_WR = 2'b01, OP_DLY = 2'b10, OP_POLL = 2'b11;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic cfg_we = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PW-1:0] cfg_idx = '0;
  logic [1:0] cfg_op = '0;
  logic [3:0] cfg_reg = '0;
  logic [31:0] cfg_arg = '0;
  logic busy, done, err;
  logic [PW-1:0] pc;
  logic [31:0] paddr, pwdata, prdata = '0;
  logic psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
  logic [3:0] pstrb;

  gpio_apb_seq #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .DELAY_WIDTH(16)) dut (
    .pclk(pclk), .presetn(presetn), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_op_i(cfg_op), .cfg_reg_i(cfg_reg), .cfg_arg_i(cfg_arg), .start_i(start),
    .abort_i(abort), .busy_o(busy), .done_o(done), .err_o(err), .pc_o(pc),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr));

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t obs_q[$];
  xfer_t snap;
  int    setup_q[$];

  logic [1:0]  p_op  [DEPTH];
  logic [3:0]  p_reg [DEPTH];
  logic [31:0] p_arg [DEPTH];
  int          rsp_wait [32];
  logic [31:0] rsp_data [32];
  logic        rsp_err  [32];

  int vectors = 0, miscompares = 0;
  int cyc = 0, t = 0, wcnt = 0, acc_cyc = 0, done_cnt = 0;
  logic exp_err;
  int   exp_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level model: walk the table, consuming scripted slave responses.
  task automatic build_model(input int abort_after);
    int mt, p;
    logic stop, hit;
    logic [31:0] a;
    exp_q.delete();
    exp_err = 1'b0;
    mt = 0;
    p = 0;
    for (int guard = 0; guard < 64; guard++) begin
      if (p_op[p] == OP_END) break;
      stop = 1'b0;
      a = BASE + 32'(p_reg[p]) * 32'd4;
      if (p_op[p] == OP_WR) begin
        exp_q.push_back('{a, 1'b1, p_arg[p], 4'hF});
        stop = rsp_err[mt];
        mt++;
      end else if (p_op[p] == OP_POLL) begin
        hit = 1'b0;
        while (!hit && !stop && mt < 32) begin
          exp_q.push_back('{a, 1'b0, 32'h0, 4'h0});
          if (rsp_err[mt]) stop = 1'b1;
          else hit = (rsp_data[mt] & p_arg[p]) != 32'h0;
          mt++;
        end
      end
      if (stop) begin
        exp_err = 1'b1;
        break;
      end
      if (abort_after > 0 && mt >= abort_after) break;
      if (p == DEPTH - 1) break;
      p++;
    end
    exp_pc = p;
  endtask

  // Scripted slave plus per-cycle protocol/scoreboard checks.
  always @(negedge pclk) begin
    cyc++;
    if (!presetn) begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
    end else begin
      if (psel || done) check("busy_active", 64'(busy), 64'd1);
      if (penable) check("penable_needs_psel", 64'(psel), 64'd1);
      if (psel && !penable) begin
        snap = '{paddr, pwrite, pwdata, pstrb};
        setup_q.push_back(cyc);
      end
      if (psel && penable) begin
        check("stable_addr", 64'(paddr), 64'(snap.addr));
        check("stable_ctl", 64'({pwrite, pstrb}), 64'({snap.wr, snap.strb}));
        check("stable_wdata", 64'(pwdata), 64'(snap.data));
        acc_cyc++;
        if (t < 32 && wcnt >= rsp_wait[t]) begin
          pready = 1'b1; prdata = rsp_data[t]; pslverr = rsp_err[t];
          if (t < exp_q.size()) begin
            check("xfer_addr", 64'(paddr), 64'(exp_q[t].addr));
            check("xfer_write", 64'(pwrite), 64'(exp_q[t].wr));
            check("xfer_strb", 64'(pstrb), 64'(exp_q[t].strb));
            if (exp_q[t].wr) check("xfer_wdata", 64'(pwdata), 64'(exp_q[t].data));
          end else begin
            vectors++;
            miscompares++;
            $display("FAIL extra_xfer: got transfer %0d to %0h, expected only %0d", t, paddr, exp_q.size());
          end
          obs_q.push_back('{paddr, pwrite, pwdata, pstrb});
          t++;
          wcnt = 0;
        end else begin
          pready = 1'b0; pslverr = 1'b0; prdata = (t < 32) ? rsp_data[t] : '0;
          wcnt++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_all();
    for (int i = 0; i < DEPTH; i++) begin
      p_op[i] = OP_END; p_reg[i] = '0; p_arg[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      rsp_wait[i] = 0; rsp_data[i] = '0; rsp_err[i] = 1'b0;
    end
  endtask

  task automatic set_step(input int i, input logic [1:0] op, input logic [3:0] r, input logic [31:0] a);
    p_op[i] = op; p_reg[i] = r; p_arg[i] = a;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge pclk);
      cfg_we = 1'b1; cfg_idx = PW'(i); cfg_op = p_op[i]; cfg_reg = p_reg[i]; cfg_arg = p_arg[i];
    end
    @(negedge pclk);
    cfg_we = 1'b0;
  endtask

  // mode 0: plain run, 1: abort during first ACCESS, 2: table writes while busy.
  task automatic run(input int mode);
    int n;
    build_model(mode == 1 ? 1 : 0);
    t = 0; wcnt = 0; acc_cyc = 0; done_cnt = 0;
    obs_q.delete(); setup_q.delete();
    @(negedge pclk); start = 1'b1;
    @(negedge pclk); start = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < 50; i++) begin
        if (penable) begin
          abort = 1'b1;
          @(negedge pclk);
          abort = 1'b0;
          break;
        end
        @(negedge pclk);
      end
    end
    if (mode == 2) begin
      for (int i = 0; i < 3; i++) begin
        cfg_we = 1'b1; cfg_idx = '0; cfg_op = OP_END; cfg_reg = '0; cfg_arg = '0;
        @(negedge pclk);
      end
      cfg_we = 1'b0;
    end
    for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge pclk);
    if (done_cnt == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done_o within 500 cycles, expected one pulse");
    end
    repeat (3) @(negedge pclk);
    n = obs_q.size();
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("err_flag", 64'(err), 64'(exp_err));
    check("final_pc", 64'(pc), 64'(exp_pc));
    check("xfer_count", 64'(n), 64'(exp_q.size()));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    clear_all();
    repeat (3) @(negedge pclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_psel", 64'({psel, penable, pwrite}), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    presetn = 1'b1;

    // Two writes back to back.
    clear_all();
    set_step(0, OP_WR, 4'd1, 32'hFF);
    set_step(1, OP_WR, 4'd2, 32'hA5);
    load_prog();
    run(0);
    if (obs_q.size() == 2) begin
      check("t1_addr0", 64'(obs_q[0].addr), 64'h4000_1004);
      check("t1_data0", 64'(obs_q[0].data), 64'hFF);
      check("t1_addr1", 64'(obs_q[1].addr), 64'h4000_1008);
      check("t1_data1", 64'(obs_q[1].data), 64'hA5);
      check("t1_setup_gap", 64'(setup_q[1] - setup_q[0]), 64'd3);
    end

    // Delay of 10 cycles between two writes, then a zero delay.
    clear_all();
    set_step(0, OP_WR, 4'd2, 32'h1);
    set_step(1, OP_DLY, 4'd0, 32'd10);
    set_step(2, OP_WR, 4'd2, 32'h0);
    load_prog();
    run(0);
    if (setup_q.size() == 2) check("t2_dly10_gap", 64'(setup_q[1] - setup_q[0]), 64'd14);
    set_step(1, OP_DLY, 4'd0, 32'd0);
    load_prog();
    run(0);
    if (setup_q.size() == 2) check("t2_dly0_gap", 64'(setup_q[1] - setup_q[0]), 64'd4);

    // Poll until bit 2 appears on the fourth read.
    clear_all();
    set_step(0, OP_POLL, 4'd1, 32'h4);
    rsp_data[3] = 32'h4;
    load_prog();
    run(0);
    check("t3_reads", 64'(obs_q.size()), 64'd4);
    if (setup_q.size() == 4) check("t3_poll_spacing", 64'(setup_q[3] - setup_q[0]), 64'd6);

    // Slave stalls five cycles on a poll that hits at once.
    rsp_data[0] = 32'hC;
    rsp_wait[0] = 5;
    run(0);
    check("t3_stall_access_cycles", 64'(acc_cyc), 64'd6);

    // Slave error on the second of three writes.
    clear_all();
    for (int i = 0; i < 3; i++) set_step(i, OP_WR, 4'(i + 3), 32'h10 + 32'(i));
    rsp_err[1] = 1'b1;
    load_prog();
    run(0);
    check("t4_writes", 64'(obs_q.size()), 64'd2);
    repeat (5) @(negedge pclk);
    check("t4_err_sticky", 64'(err), 64'd1);
    rsp_err[1] = 1'b0;
    run(0);
    check("t4_err_cleared", 64'(err), 64'd0);

    // Abort during a stalled first write of four.
    clear_all();
    for (int i = 0; i < 4; i++) set_step(i, OP_WR, 4'(i), 32'h20 + 32'(i));
    rsp_wait[0] = 3;
    load_prog();
    run(1);
    check("t5_writes", 64'(obs_q.size()), 64'd1);

    // Full table without END, with table writes attempted while busy.
    clear_all();
    for (int i = 0; i < DEPTH; i++) set_step(i, OP_WR, 4'(i + 8), 32'h100 + 32'(i));
    load_prog();
    run(2);
    check("t6_writes", 64'(obs_q.size()), 64'd8);
    check("t6_pc", 64'(pc), 64'd7);
    run(0);
    check("t6_table_kept", 64'(obs_q.size()), 64'd8);

    // Reset in the middle of a stalled access.
    clear_all();
    set_step(0, OP_WR, 4'd3, 32'h12);
    rsp_wait[0] = 10;
    load_prog();
    build_model(0);
    t = 0; wcnt = 0;
    @(negedge pclk); start = 1'b1;
    @(negedge pclk); start = 1'b0;
    for (int i = 0; i < 20 && !penable; i++) @(negedge pclk);
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check("t7_psel", 64'(psel), 64'd0);
    check("t7_penable", 64'(penable), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_pc", 64'(pc), 64'd0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
